// File: rtl/shift_pkg.sv
// Shared constants and types for the shift / shift_deser pair.
// Holds the default word width and the receiver FSM state encoding.
package shift_pkg;

  localparam int DEF_BITS  = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    SYNC = 1'b0,
    HUNT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/shift_deser_if.sv
// Valid/ready word port of the serial receiver.
// master: drives out_data/out_valid; slave: drives out_ready.
interface shift_deser_if #(
  parameter int BITS = 8
) ();

  logic [BITS-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/shift_fifo.sv
// Circular word FIFO; pointers carry one extra wrap bit.
// Ports: push_i/data_i, pop_i, full_o, empty_o, level_o, head_o.
module shift_fifo
  import shift_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [BITS-1:0]          data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [BITS-1:0]          head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_q, wr_d;
  logic [AW:0]     rd_q, rd_d;
  logic [BITS-1:0] mem_q [DEPTH];
  logic            do_push;
  logic            do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;

  // Read out zero while empty so a drained FIFO looks like reset.
  assign head_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  // A same-cycle pop frees the slot a full FIFO needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver with eos framing check and word FIFO.
// Ports: sdi/sdi_valid/eos in, out_if word port, level, sticky errors.
module shift_deser
  import shift_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sdi,
  input  logic                   sdi_valid,
  input  logic                   eos,
  shift_deser_if.master          out_if,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_err,
  output logic                   ovf_err,
  input  logic                   err_clr
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  deser_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Only the older BITS-1 bits are kept; the live bit completes the word.
  logic [BITS-2:0] sr_q, sr_d;
  logic            fe_q, fe_d;
  logic            ovf_q, ovf_d;

  logic [BITS-1:0] word;
  logic            push;
  logic            fe_set;
  logic            ovf_set;
  logic            pop;
  logic            full;
  logic            empty;

  assign word = {sr_q, sdi};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    if (sdi_valid) begin
      unique case (state_q)
        SYNC: begin
          sr_d = word[BITS-2:0];
          if (eos) begin
            cnt_d = '0;
            if (cnt_q == LAST) push = 1'b1;
            else               fe_set = 1'b1;
          end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            fe_set  = 1'b1;
            state_d = HUNT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HUNT: begin
          if (eos) begin
            state_d = SYNC;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop     = out_if.out_valid && out_if.out_ready;
  assign ovf_set = push && full && !pop;

  // Clear loses to a fresh error in the same cycle.
  assign fe_d  = (fe_q  && !err_clr) || fe_set;
  assign ovf_d = (ovf_q && !err_clr) || ovf_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      sr_q    <= '0;
      fe_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      fe_q    <= fe_d;
      ovf_q   <= ovf_d;
    end
  end

  shift_fifo #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (word),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level),
    .head_o  (out_if.out_data)
  );

  assign out_if.out_valid = !empty;
  assign frame_err        = fe_q;
  assign ovf_err          = ovf_q;

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel receiver that sits directly downstream of the `shift` parallel-in/serial-out stage. It consumes the one-bit serial stream and its end-of-shift marker, reassembles `BITS`-wide words, and checks framing against the marker. Completed words go into a small FIFO behind a valid/ready output port. Sticky error flags report framing faults and overflow for the Tiny Tapeout top level.

## Interface

Parameters:
- `BITS`, default 8: word width; must match the upstream `shift` instance.
- `DEPTH`, default 4: FIFO depth in words; power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sdi`  in  1  serial data bit, MSB first.
- `sdi_valid`  in  1  qualifies `sdi`/`eos`; one bit consumed per cycle it is high.
- `eos`  in  1  end-of-shift: high together with the last (LSB) bit of a word; ignored when `sdi_valid`=0.
- `out_data`  out  BITS  head-of-FIFO word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `frame_err`  out  1  sticky framing error.
- `ovf_err`  out  1  sticky overflow (word dropped).
- `err_clr`  in  1  clears both sticky flags.

## Operation

- FSM states:
  - SYNC: assembling a word, bit counter `cnt` 0..BITS-1.
  - HUNT: discarding bits while waiting for resynchronisation.
- SYNC, on `sdi_valid`: shift `sr <= {sr[BITS-2:0], sdi}`.
  - `eos`=1 and `cnt`=BITS-1: the word is complete. Push `{sr[BITS-2:0], sdi}`, then `cnt` <= 0.
  - `eos`=1 and `cnt`<BITS-1 (short frame): discard the partial word, set `frame_err`, `cnt` <= 0, stay in SYNC. The next bit starts a new word.
  - `eos`=0 and `cnt`=BITS-1 (missing marker): discard, set `frame_err`, go to HUNT.
  - Otherwise: `cnt` <= `cnt`+1.
- HUNT, on `sdi_valid`: bits are ignored. A bit with `eos`=1 moves the FSM to SYNC with `cnt` = 0.
- FIFO push when full: the word is dropped and `ovf_err` is set. Exception: a pop in the same cycle frees a slot, so the push is accepted and `level` is unchanged.
- Pop and push in the same cycle with a non-empty FIFO: `level` is unchanged and ordering is preserved.
- `err_clr`: clears both flags. If a new error occurs in the same cycle, set wins.
- `sdi_valid` gaps in mid-word are allowed; the counter and shift register hold.
- Reset values: FSM=SYNC, `cnt`=0, `sr`=0, FIFO empty, `level`=0, `out_valid`=0, `out_data`=0, `frame_err`=0, `ovf_err`=0.
- Reset mid-word or with the FIFO non-empty: everything is discarded and the block returns to the reset values above.

## Timing

- Latency: the final bit is sampled at edge N. `out_valid`=1 and `out_data` is valid after edge N (first-word fall-through, one cycle).
- `out_data` holds stable while `out_valid && !out_ready`.
- Error flags assert after the edge that samples the offending bit.
- `level` updates on the same edge as push/pop.
- Throughput: one word per BITS valid cycles. There are no dead cycles between back-to-back words.

## Structure

- Shared package `shift_pkg`:
  - `BITS` default constant, shared with `shift`.
  - FSM state enum `deser_state_t` {SYNC, HUNT}.
- Sub-module `shift_fifo` (params BITS, DEPTH): circular buffer with read/write pointers carrying one extra wrap bit.
  - Interface: push, pop, full, empty, level, head data.
- The top of `shift_deser` holds the FSM, counter, shift register, error flags, and the `shift_fifo` instance.

## Test plan

- Send 0xA5 MSB-first with `eos` on the 8th bit, `out_ready`=1 -> `out_valid` high for one cycle after the last bit, `out_data`=0xA5, `level` 1 then 0, no flags.
- Hold `out_ready`=0 and send 0x01..0x05 -> `level`=4, `ovf_err`=1. Draining yields 0x01,0x02,0x03,0x04. With full FIFO, push plus simultaneous pop -> word accepted, no `ovf_err`.
- `eos` on the 5th bit -> `frame_err`=1, nothing pushed. The following full frame 0x3C is received correctly. Then `err_clr` -> `frame_err`=0.
- 8 bits with no `eos` -> `frame_err`=1, HUNT. Junk bits are ignored until an `eos` bit. The next frame 0x7E is received.
- 0xC3 sent with random `sdi_valid` gaps, including a gap just before the `eos` bit -> `out_data`=0xC3.
- `rst` asserted mid-word while the FIFO holds 2 words and both flags are set -> after the edge `level`=0, `out_valid`=0, flags 0. The next frame 0x5A is received correctly.
